// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store sequencer for a big-endian word-wide data memory
// Handles LB/LH/LW(U) extraction, SB/SH read-modify-write and misalignment flagging.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        done_q;
  logic        error_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic [31:0] wr_data_q;
  logic        misaligned;
  logic        is_load;

  // Lanes are big-endian: byte offset 0 is the most significant byte.
  function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (o)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] off,
                                        input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (o == OP_SB) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d[15:0];
    end else begin
      r[31:16] = d[15:0];
    end
    return r;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0])
      misaligned = 1'b1;
    if ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00)
      misaligned = 1'b1;
    is_load = !(op == OP_SB || op == OP_SH || op == OP_SW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata_q   <= 32'h0;
      wr_data_q <= 32'h0;
    end else begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= 32'h0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            ready_q <= 1'b0;
            if (misaligned) begin
              state   <= RESP;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (is_load) begin
              state <= LOAD;
              rd_q  <= 1'b1;
            end else if (op == OP_SW) begin
              state     <= STORE_WR;
              wr_q      <= 1'b1;
              wr_data_q <= wdata;
            end else begin
              state <= STORE_RD;
              rd_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q <= extract(op_q, addr_q[1:0], mem_read_data);
          state   <= RESP;
          done_q  <= 1'b1;
        end
        STORE_RD: begin
          // The write-data register doubles as the merge register.
          wr_data_q <= merge(op_q, addr_q[1:0], mem_read_data, wdata_q);
          wr_q      <= 1'b1;
          state     <= STORE_WR;
        end
        STORE_WR: begin
          state  <= RESP;
          done_q <= 1'b1;
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Enables are masked by reset so an interrupted store can never reach memory.
  assign MemRead        = rd_q && !reset;
  assign MemWrite       = wr_q && !reset;
  assign ready          = ready_q;
  assign done           = done_q;
  assign error          = error_q;
  assign rdata          = rdata_q;
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// A small word memory model sits on the memory port; expected values are hand-computed.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic        done;
  logic        error;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_read_data;

  logic        preload = 1'b1;
  logic [31:0] mem [0:63];

  int          total = 0;
  int          bad = 0;
  int          n_cyc;
  int          n_rd;
  int          n_wr;
  logic        got_done;
  logic        err;
  logic [31:0] wr_word;
  logic [31:0] seen_addr;

  load_store_unit dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .op             (op),
    .addr           (addr),
    .wdata          (wdata),
    .ready          (ready),
    .done           (done),
    .error          (error),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (MemWrite) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Issues one request, then scrambles the inputs to prove the latched copies are used.
  task automatic run_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    check_eq("ready_before", {31'b0, ready}, 32'd1);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clock);
    req = 1'b0; op = ~o; addr = ~a; wdata = ~wd;
    n_cyc = 0; n_rd = 0; n_wr = 0; got_done = 1'b0; err = 1'b0;
    wr_word = 32'h0; seen_addr = 32'hFFFF_FFFF;
    while (!got_done && n_cyc < 8) begin
      n_cyc++;
      if (MemRead) n_rd++;
      if (MemWrite) begin n_wr++; wr_word = mem_write_data; end
      if (MemRead || MemWrite) seen_addr = mem_address;
      if (done) begin got_done = 1'b1; err = error; end
      else @(negedge clock);
    end
    check_eq("done_seen", {31'b0, got_done}, 32'd1);
  endtask

  task automatic load_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] exp);
    run_access(o, a, 32'h0);
    check_eq({tag, "_rdata"}, rdata, exp);
    check_eq({tag, "_lat"}, n_cyc, 32'd2);
    check_eq({tag, "_addr"}, seen_addr, 32'h10);
    check_eq({tag, "_rd"}, n_rd, 32'd1);
    check_eq({tag, "_wr"}, n_wr, 32'd0);
    check_eq({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic store_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] wd, input int exp_rd, input int exp_lat,
                            input logic [31:0] exp_word);
    run_access(o, a, wd);
    check_eq({tag, "_word"}, wr_word, exp_word);
    check_eq({tag, "_lat"}, n_cyc, exp_lat);
    check_eq({tag, "_addr"}, seen_addr, 32'h10);
    check_eq({tag, "_rd"}, n_rd, exp_rd);
    check_eq({tag, "_wr"}, n_wr, 32'd1);
    check_eq({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic misaligned_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] exp_rdata);
    run_access(o, a, 32'h0000_7777);
    check_eq({tag, "_lat"}, n_cyc, 32'd1);
    check_eq({tag, "_err"}, {31'b0, err}, 32'd1);
    check_eq({tag, "_rd"}, n_rd, 32'd0);
    check_eq({tag, "_wr"}, n_wr, 32'd0);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    // Hold reset with a request pending; the request must be ignored.
    req = 1'b1; op = 3'b010; addr = 32'h10;
    repeat (3) @(negedge clock);
    check_eq("rst_ready", {31'b0, ready}, 32'd1);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_error", {31'b0, error}, 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_maddr", mem_address, 32'h0);
    check_eq("rst_mwdata", mem_write_data, 32'h0);
    check_eq("rst_mrd", {31'b0, MemRead}, 32'd0);
    check_eq("rst_mwr", {31'b0, MemWrite}, 32'd0);
    reset = 1'b0; preload = 1'b0; req = 1'b0;
    @(negedge clock);
    check_eq("rst_req_ignored", {31'b0, ready}, 32'd1);

    load_case("lb",  3'b000, 32'h11, 32'hFFFF_FF99);
    load_case("lbu", 3'b100, 32'h11, 32'h0000_0099);
    load_case("lh",  3'b001, 32'h12, 32'hFFFF_AABB);
    load_case("lhu", 3'b101, 32'h10, 32'h0000_8899);
    load_case("lw",  3'b010, 32'h10, 32'h8899_AABB);

    store_case("sb", 3'b011, 32'h13, 32'h1234_56CC, 1, 3, 32'h8899_AACC);
    store_case("sh", 3'b110, 32'h10, 32'h0000_1111, 1, 3, 32'h1111_AACC);
    load_case("lw_after_sh", 3'b010, 32'h10, 32'h1111_AACC);
    store_case("sw", 3'b111, 32'h10, 32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF);
    load_case("lw_after_sw", 3'b010, 32'h10, 32'hDEAD_BEEF);
    load_case("lb_neg", 3'b000, 32'h13, 32'hFFFF_FFEF);
    load_case("lbu_pos", 3'b100, 32'h12, 32'h0000_00BE);

    misaligned_case("mis_lw", 3'b010, 32'h12, 32'h0000_00BE);
    misaligned_case("mis_sh", 3'b110, 32'h11, 32'h0000_00BE);

    // Reset lands during STORE_WR of an SB; the write must be suppressed.
    @(negedge clock);
    req = 1'b1; op = 3'b011; addr = 32'h10; wdata = 32'h0000_0055;
    @(negedge clock);
    req = 1'b0;
    check_eq("rw_store_rd", {31'b0, MemRead}, 32'd1);
    @(negedge clock);
    check_eq("rw_store_wr", {31'b0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rw_wr_gated", {31'b0, MemWrite}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check_eq("rw_ready", {31'b0, ready}, 32'd1);
    check_eq("rw_no_done", {31'b0, done}, 32'd0);
    check_eq("rw_mem", mem[4], 32'hDEAD_BEEF);
    @(negedge clock);
    check_eq("rw_no_done2", {31'b0, done}, 32'd0);
    load_case("lw_after_rst", 3'b010, 32'h10, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store sequencer sitting directly upstream of the byte-addressed, big-endian data memory, between the CPU's MEM stage and the memory port. Accepts one access request at a time: LB/LBU/LH/LHU/LW/SB/SH/SW. Always drives word-aligned addresses. Performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write merging for SB/SH, since the memory writes only whole words. Flags misaligned accesses without touching memory.

## Interface
- No parameters; address/data widths fixed at 32.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  access request; sampled only while ready=1.
- op  in  3  access type:
  - 000 LB, 001 LH, 010 LW, 011 SB
  - 100 LBU, 101 LHU, 110 SH, 111 SW
- addr  in  32  byte address of the access.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when the access completes.
- error  out  1  valid with done; 1 = misaligned, no memory access made.
- rdata  out  32  load result, extended; held until the next done.
- mem_address  out  32  {addr_q[31:2],2'b00} to memory.
- mem_write_data  out  32  merged word; 0 except in STORE_WR.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable; memory writes on the rising edge while high.
- mem_read_data  in  32  combinational read data from memory, valid in the same cycle as MemRead.

## Operation
- States: IDLE, LOAD, STORE_RD, STORE_WR, RESP.
- IDLE, req=1: latch op, addr, wdata into op_q, addr_q, wdata_q, then check alignment.
  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Go to RESP with error_q=1.
  - Loads go to LOAD.
  - SW goes to STORE_WR.
  - SB/SH go to STORE_RD.
- LOAD: MemRead=1. Capture the extracted value into rdata, then go to RESP.
- STORE_RD: MemRead=1. Capture mem_read_data into merge register, then go to STORE_WR.
- STORE_WR: MemWrite=1, then go to RESP.
  - SW: mem_write_data = wdata_q.
  - SB/SH: mem_write_data = captured word with the target lane replaced.
- RESP: done=1, error=error_q, then go to IDLE. No new request is accepted in RESP.
- Lanes are big-endian:
  - Bytes: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Halves: offset 0 → [31:16], 2 → [15:0].
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- rdata is not updated by stores or misaligned accesses.
- MemRead and MemWrite are never high simultaneously. Both are 0 in IDLE and RESP.
- MemRead and MemWrite are gated combinationally with !reset, so no memory write occurs in any cycle where reset=1.

## Timing
- Reset values: state=IDLE, ready=1, done=0, error=0, rdata=0, mem_address=0, mem_write_data=0, MemRead=0, MemWrite=0.
- Cycle 0 is the acceptance edge.
- Latency from acceptance to done:
  - Loads: 2 cycles (LOAD, RESP).
  - SW: 2 cycles (STORE_WR, RESP).
  - SB/SH: 3 cycles (STORE_RD, STORE_WR, RESP).
  - Misaligned: 1 cycle (RESP).
- Throughput: the next request can be accepted in the cycle after RESP.
- ready falls in the cycle after acceptance.
- req or input changes while ready=0 are ignored; the latched values are used.
- reset in any state returns to IDLE at that edge. The in-flight access is dropped: no done, no write.
- req together with reset is ignored.

## Test plan
- Memory word 0x10 = 0x8899AABB.
  - LB 0x11 → rdata 0xFFFFFF99, done 2 cycles after acceptance.
  - LBU 0x11 → 0x00000099.
- LH 0x12 → 0xFFFFAABB; LHU 0x10 → 0x00008899; LW 0x10 → 0x8899AABB.
  - Check mem_address=0x10 for every case.
- SB 0x13 wdata 0x123456CC → one read cycle, then one write cycle with mem_write_data=0x8899AACC.
  - Then SH 0x10 wdata 0x00001111 → word 0x1111AACC.
  - done 3 cycles after each acceptance.
- SW 0x10 wdata 0xDEADBEEF:
  - No MemRead cycle.
  - MemWrite for exactly 1 cycle.
  - LW then returns 0xDEADBEEF.
- Misaligned:
  - LW 0x12 and SH 0x11 → done+error=1 one cycle after acceptance.
  - MemRead/MemWrite never asserted.
  - rdata unchanged.
- Reset asserted during STORE_WR of SB 0x10:
  - MemWrite=0 that cycle; memory unchanged.
  - No done; state back to IDLE, ready=1 the next cycle.
  - A following LW 0x10 returns the original word.
